// File: rtl/ccm_ecc_scrubber.sv
// Background ECC scrubber for a single-port 32-bit SRAM with a 7-bit SECDED (Hamming 39,32) code.
// Reads each word in turn, writes back single-bit corrections, reports double-bit errors.
module ccm_ecc_scrubber #(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int INTERVAL = 256
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              scrub_en,
  output logic              scrub_req,
  input  logic              scrub_gnt,
  output logic              scrub_wen,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic [31:0]       scrub_wdata,
  output logic [6:0]        scrub_wecc,
  input  logic [31:0]       mem_rdata,
  input  logic [6:0]        mem_recc,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_wr_addr,
  output logic              sec_pulse,
  output logic              ded_pulse,
  output logic [ADDR_W-1:0] err_addr,
  output logic              pass_done,
  output logic [15:0]       sec_cnt,
  output logic [15:0]       ded_cnt,
  input  logic              cnt_clr
);

  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(INTERVAL - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
  localparam logic [15:0]       CNT_SAT  = 16'hFFFF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  typedef struct packed {
    logic        sec;
    logic        ded;
    logic [31:0] dout;
    logic [6:0]  eout;
  } dec_t;

  // Codeword positions 1..38: powers of two carry ecc[5:0], the rest carry data in order.
  function automatic dec_t ecc_decode(input logic [31:0] d, input logic [6:0] e);
    dec_t        r;
    logic [38:0] cw;
    logic [5:0]  syn;
    logic        ovr;
    int          k;
    int          m;
    r   = '0;
    cw  = '0;
    syn = 6'd0;
    k   = 0;
    m   = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) == 0) begin
        cw[p] = e[m];
        m++;
      end else begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      for (int p = 1; p < 39; p++) begin
        if (p[j]) syn[j] = syn[j] ^ cw[p];
      end
    end
    ovr   = ^{d, e};
    r.sec = ovr;
    r.ded = ~ovr & (syn != 6'd0);
    if (ovr && (syn != 6'd0) && (syn <= 6'd38)) cw[syn] = ~cw[syn];
    k = 0;
    m = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) == 0) begin
        r.eout[m] = cw[p];
        m++;
      end else begin
        r.dout[k] = cw[p];
        k++;
      end
    end
    r.eout[6] = e[6] ^ (ovr & (syn == 6'd0));
    return r;
  endfunction

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              stale_r;
  logic              xfer_s;
  logic              core_hit_s;
  logic              advance_s;
  logic              latch_s;
  logic              sec_s;
  logic              ded_s;
  logic [2:0]        resume_s;
  dec_t              dec_s;

  assign scrub_req  = (state_r == S_READ) | ((state_r == S_WRITE) & ~stale_r);
  assign scrub_wen  = (state_r == S_WRITE);
  assign scrub_addr = ptr_r;
  assign xfer_s     = scrub_req & scrub_gnt;
  assign core_hit_s = core_wr & (core_wr_addr == ptr_r);
  assign dec_s      = ecc_decode(mem_rdata, mem_recc);
  assign resume_s   = scrub_en ? S_WAIT : S_IDLE;

  // Next-state decode; a disabled scrubber still finishes the entry it is checking or writing.
  always_comb begin
    state_nxt_s = state_r;
    advance_s   = 1'b0;
    latch_s     = 1'b0;
    sec_s       = 1'b0;
    ded_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (scrub_en) state_nxt_s = S_WAIT;
        else          state_nxt_s = S_IDLE;
      end
      S_WAIT: begin
        if (!scrub_en)             state_nxt_s = S_IDLE;
        else if (cnt_r == CNT_ZERO) state_nxt_s = S_READ;
        else                       state_nxt_s = S_WAIT;
      end
      S_READ: begin
        if (xfer_s)         state_nxt_s = S_CHECK;
        else if (!scrub_en) state_nxt_s = S_IDLE;
        else                state_nxt_s = S_READ;
      end
      S_CHECK: begin
        if (dec_s.sec) begin
          sec_s       = 1'b1;
          latch_s     = 1'b1;
          state_nxt_s = S_WRITE;
        end else if (dec_s.ded) begin
          ded_s       = 1'b1;
          advance_s   = 1'b1;
          state_nxt_s = resume_s;
        end else begin
          advance_s   = 1'b1;
          state_nxt_s = resume_s;
        end
      end
      S_WRITE: begin
        if (stale_r || xfer_s) begin
          advance_s   = 1'b1;
          state_nxt_s = resume_s;
        end else begin
          state_nxt_s = S_WRITE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, address pointer, interval counter and wrap pulse.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r   <= S_IDLE;
      ptr_r     <= PTR_ZERO;
      cnt_r     <= CNT_ZERO;
      pass_done <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pass_done <= advance_s & (ptr_r == PTR_LAST);
      if (advance_s) ptr_r <= (ptr_r == PTR_LAST) ? PTR_ZERO : ptr_r + PTR_ONE;
      if ((state_nxt_s == S_WAIT) && (state_r != S_WAIT)) cnt_r <= CNT_LOAD;
      else if ((state_r == S_WAIT) && (cnt_r != CNT_ZERO)) cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // A core write to the entry under repair makes the corrected copy stale.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      stale_r <= 1'b0;
    end else if (state_r == S_CHECK) begin
      stale_r <= core_hit_s;
    end else if ((state_r == S_WRITE) && core_hit_s) begin
      stale_r <= 1'b1;
    end
  end

  // Corrected write-back data.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      scrub_wdata <= 32'd0;
      scrub_wecc  <= 7'd0;
    end else if (latch_s) begin
      scrub_wdata <= dec_s.dout;
      scrub_wecc  <= dec_s.eout;
    end
  end

  // Error pulses and last error address.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sec_pulse <= 1'b0;
      ded_pulse <= 1'b0;
      err_addr  <= PTR_ZERO;
    end else begin
      sec_pulse <= sec_s;
      ded_pulse <= ded_s;
      if (sec_s || ded_s) err_addr <= ptr_r;
    end
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sec_cnt <= 16'd0;
      ded_cnt <= 16'd0;
    end else if (cnt_clr) begin
      sec_cnt <= 16'd0;
      ded_cnt <= 16'd0;
    end else begin
      if (sec_s && (sec_cnt != CNT_SAT)) sec_cnt <= sec_cnt + 16'd1;
      if (ded_s && (ded_cnt != CNT_SAT)) ded_cnt <= ded_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ccm_ecc_scrubber.sv
// Directed bench for ccm_ecc_scrubber: one annotated pass over a small memory, then
// grant stall / disable, counter saturation and clear, and a mid-write reset.
module tb_ccm_ecc_scrubber;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int INTERVAL = 4;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          scrub_en;
  logic          scrub_req;
  logic          scrub_gnt;
  logic          scrub_wen;
  logic [AW-1:0] scrub_addr;
  logic [31:0]   scrub_wdata;
  logic [6:0]    scrub_wecc;
  logic [31:0]   mem_rdata;
  logic [6:0]    mem_recc;
  logic          core_wr;
  logic [AW-1:0] core_wr_addr;
  logic [31:0]   core_data;
  logic          sec_pulse;
  logic          ded_pulse;
  logic [AW-1:0] err_addr;
  logic          pass_done;
  logic [15:0]   sec_cnt;
  logic [15:0]   ded_cnt;
  logic          cnt_clr;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [31:0] mem_d  [DEPTH];
  logic [6:0]  mem_e  [DEPTH];
  logic [31:0] flip_d [DEPTH];
  logic [6:0]  flip_e [DEPTH];
  bit          x_sec  [DEPTH];
  bit          x_ded  [DEPTH];
  bit          x_hit  [DEPTH];

  typedef struct {
    int          addr;
    logic [31:0] fd;
    logic [6:0]  fe;
    bit          core_hit;
    bit          e_sec;
    bit          e_ded;
  } vec_t;
  vec_t vecs [7];

  ccm_ecc_scrubber #(.DEPTH(DEPTH), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .rst_l(rst_l), .scrub_en(scrub_en), .scrub_req(scrub_req),
    .scrub_gnt(scrub_gnt), .scrub_wen(scrub_wen), .scrub_addr(scrub_addr),
    .scrub_wdata(scrub_wdata), .scrub_wecc(scrub_wecc), .mem_rdata(mem_rdata),
    .mem_recc(mem_recc), .core_wr(core_wr), .core_wr_addr(core_wr_addr),
    .sec_pulse(sec_pulse), .ded_pulse(ded_pulse), .err_addr(err_addr),
    .pass_done(pass_done), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // Hamming(39,32) encoder: data bit i sits at the i-th non-power-of-two position from 3 up.
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [6:0] e;
    int pos;
    e = 7'd0;
    pos = 2;
    for (int i = 0; i < 32; i++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      for (int j = 0; j < 6; j++) if (pos[j]) e[j] = e[j] ^ d[i];
    end
    e[6] = ^{d, e[5:0]};
    return e;
  endfunction

  function automatic logic [31:0] clean(input int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model with read-path bit-flip injection.
  always @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= clean(i);
        mem_e[i] <= enc(clean(i));
      end
      mem_rdata <= 32'd0;
      mem_recc  <= 7'd0;
    end else begin
      if (scrub_req && scrub_gnt && !scrub_wen) begin
        mem_rdata <= mem_d[scrub_addr] ^ flip_d[scrub_addr];
        mem_recc  <= mem_e[scrub_addr] ^ flip_e[scrub_addr];
      end
      if (scrub_req && scrub_gnt && scrub_wen) begin
        mem_d[scrub_addr] <= scrub_wdata;
        mem_e[scrub_addr] <= scrub_wecc;
      end
      if (core_wr) begin
        mem_d[core_wr_addr] <= core_data;
        mem_e[core_wr_addr] <= enc(core_data);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_read(input bit need_gnt, output int a);
    bit found;
    found = 1'b0;
    a = -1;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (scrub_req && !scrub_wen && (scrub_gnt || !need_gnt)) begin
        a = int'(scrub_addr);
        found = 1'b1;
      end
    end
    if (!found) begin
      n_chk++;
      $display("FAIL read_timeout: got no read request, expected one within 200 cycles");
    end
  endtask

  initial begin
    int a;
    int prev_cyc;
    int en_cyc;
    int bad;
    bit prev_sec;

    rst_l = 1'b0; scrub_en = 1'b0; scrub_gnt = 1'b1; core_wr = 1'b0;
    core_wr_addr = '0; core_data = 32'd0; cnt_clr = 1'b0;

    vecs[0] = '{3,  32'h0000_0020, 7'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{5,  32'h0000_0000, 7'h04, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{7,  32'h0010_0002, 7'h00, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{9,  32'h0000_0001, 7'h00, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{11, 32'h0000_0000, 7'h40, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{12, 32'h8000_0000, 7'h00, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{14, 32'h0000_0001, 7'h08, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < DEPTH; i++) begin
      flip_d[i] = 32'd0; flip_e[i] = 7'd0;
      x_sec[i] = 1'b0; x_ded[i] = 1'b0; x_hit[i] = 1'b0;
    end
    for (int v = 0; v < 7; v++) begin
      flip_d[vecs[v].addr] = vecs[v].fd;
      flip_e[vecs[v].addr] = vecs[v].fe;
      x_sec[vecs[v].addr]  = vecs[v].e_sec;
      x_ded[vecs[v].addr]  = vecs[v].e_ded;
      x_hit[vecs[v].addr]  = vecs[v].core_hit;
    end

    repeat (3) @(negedge clk);
    chk("rst_req", 32'(scrub_req), 32'd0);
    chk("rst_wen", 32'(scrub_wen), 32'd0);
    chk("rst_addr", 32'(scrub_addr), 32'd0);
    chk("rst_wdata", scrub_wdata, 32'd0);
    chk("rst_pulses", 32'({sec_pulse, ded_pulse, pass_done}), 32'd0);
    chk("rst_cnts", {sec_cnt, ded_cnt}, 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);

    rst_l = 1'b1;
    scrub_en = 1'b1;
    prev_cyc = 0;
    prev_sec = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wait_read(1'b1, a);
      chk("rd_addr", 32'(a), 32'(i));
      if (i > 0) chk("rd_gap", 32'(cyc - prev_cyc), 32'(INTERVAL + 2 + (prev_sec ? 1 : 0)));
      prev_cyc = cyc;
      prev_sec = x_sec[i];
      @(negedge clk);
      if (x_hit[i]) begin
        core_wr = 1'b1; core_wr_addr = AW'(i); core_data = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      core_wr = 1'b0;
      chk("sec_pulse", 32'(sec_pulse), 32'(x_sec[i]));
      chk("ded_pulse", 32'(ded_pulse), 32'(x_ded[i]));
      chk("pass_done", 32'(pass_done), 32'(i == DEPTH - 1));
      if (x_sec[i] || x_ded[i]) chk("err_addr", 32'(err_addr), 32'(i));
      if (x_sec[i] && !x_hit[i]) begin
        chk("wr_req", 32'({scrub_req, scrub_wen}), 32'd3);
        chk("wr_addr", 32'(scrub_addr), 32'(i));
        chk("wr_data", scrub_wdata, clean(i));
        chk("wr_ecc", 32'(scrub_wecc), 32'(enc(clean(i))));
      end else begin
        chk("no_wr", 32'(scrub_req && scrub_wen), 32'd0);
      end
    end
    chk("pass_sec_cnt", 32'(sec_cnt), 32'd5);
    chk("pass_ded_cnt", 32'(ded_cnt), 32'd2);
    for (int i = 0; i < DEPTH; i++) begin
      flip_d[i] = 32'd0; flip_e[i] = 7'd0;
    end

    // Wrap back to address 0, then stall the grant on address 1.
    wait_read(1'b1, a);
    chk("wrap_addr", 32'(a), 32'd0);
    chk("wrap_gap", 32'(cyc - prev_cyc), 32'(INTERVAL + 2));
    @(negedge clk);
    scrub_gnt = 1'b0;
    wait_read(1'b0, a);
    chk("stall_addr", 32'(a), 32'd1);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!scrub_req || scrub_wen || scrub_addr != AW'(1)) bad++;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    scrub_en = 1'b0;
    @(negedge clk);
    chk("dis_req", 32'(scrub_req), 32'd0);
    chk("dis_addr", 32'(scrub_addr), 32'd1);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (scrub_req) bad++;
    end
    chk("dis_idle", 32'(bad), 32'd0);
    scrub_gnt = 1'b1;
    scrub_en = 1'b1;
    en_cyc = cyc;
    wait_read(1'b1, a);
    chk("resume_addr", 32'(a), 32'd1);
    chk("resume_gap", 32'(cyc - en_cyc), 32'(INTERVAL + 1));

    // Saturation at FFFF, then clear coinciding with an increment.
    flip_d[2] = 32'h0000_0080;
    flip_d[3] = 32'h0000_0200;
    @(negedge clk);
    force dut.sec_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.sec_cnt;
    wait_read(1'b1, a);
    chk("sat_addr", 32'(a), 32'd2);
    repeat (2) @(negedge clk);
    chk("sat_pulse", 32'(sec_pulse), 32'd1);
    chk("sat_cnt", 32'(sec_cnt), 32'h0000_FFFF);
    wait_read(1'b1, a);
    chk("clr_addr", 32'(a), 32'd3);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_sec_cnt", 32'(sec_cnt), 32'd0);
    chk("clr_ded_cnt", 32'(ded_cnt), 32'd0);
    chk("clr_err_addr", 32'(err_addr), 32'd3);
    chk("clr_wr_data", scrub_wdata, clean(3));
    chk("clr_wr_req", 32'({scrub_req, scrub_wen}), 32'd3);

    // Reset in the middle of a pending write.
    rst_l = 1'b0;
    #1;
    chk("mrst_req", 32'(scrub_req), 32'd0);
    chk("mrst_addr", 32'(scrub_addr), 32'd0);
    chk("mrst_wdata", scrub_wdata, 32'd0);
    chk("mrst_err_addr", 32'(err_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
